// File: rtl/fir_mc_if.sv
// Sample/coefficient input and tagged-result output bundle for fir_mc.
// The master drives samples and coefficients; the slave (the FIR engine) drives results.
interface fir_mc_if #(
    parameter int DataWidth = 12,
    parameter int ChW       = 1
);
    logic                 in_valid;
    logic                 in_ready;
    logic [ChW-1:0]       in_ch;
    logic                 in_sym;
    logic [DataWidth-1:0] x;
    logic                 coeff_load_in;
    logic                 coeff_in;
    logic                 out_valid;
    logic [ChW-1:0]       out_ch;
    logic [DataWidth-1:0] y;
    logic                 out_sat;
    logic                 ch_err;

    modport master (
        output in_valid, in_ch, in_sym, x, coeff_load_in, coeff_in,
        input  in_ready, out_valid, out_ch, y, out_sat, ch_err
    );

    modport slave (
        input  in_valid, in_ch, in_sym, x, coeff_load_in, coeff_in,
        output in_ready, out_valid, out_ch, y, out_sat, ch_err
    );
endinterface

// File: rtl/fir_mc.sv
// Multi-channel bit-serial linear-phase FIR: result strobes NCoeffs*DataWidth+1 cycles after accept.
// in_ready is low while loading coefficients or computing; one sample in flight at a time.
module fir_mc #(
    parameter int DataWidth = 12,
    parameter int NTaps     = 9,
    parameter int NChannels = 2
) (
    input logic    clk,
    input logic    rstN,
    fir_mc_if.slave bus
);
    localparam int NCoeffs = (NTaps + 1) / 2;
    localparam int ChW     = (NChannels > 1) ? $clog2(NChannels) : 1;
    localparam int AccW    = 2 * DataWidth + $clog2(NTaps) + 1;
    localparam int CoefW   = NCoeffs * DataWidth;
    localparam int LineW   = NTaps * DataWidth;
    localparam int KW      = (NCoeffs > 1) ? $clog2(NCoeffs) : 1;
    localparam int BW      = $clog2(DataWidth);
    localparam logic [ChW:0]             ChLimit = (ChW + 1)'(NChannels);
    localparam logic signed [AccW-1:0]   YMax    = AccW'((2 ** (DataWidth - 1)) - 1);
    localparam logic signed [AccW-1:0]   YMin    = -YMax - AccW'(1);

    if ((NTaps % 2) == 0 || NTaps < 3) begin : g_bad_ntaps
        $error("fir_mc: NTaps must be odd and >= 3");
    end
    if (NChannels < 1) begin : g_bad_nch
        $error("fir_mc: NChannels must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

    state_t                          r_state, w_state_nxt;
    logic [NChannels-1:0][LineW-1:0] r_dl;
    logic [CoefW-1:0]                r_coef;
    logic signed [AccW-1:0]          r_acc;
    logic [ChW-1:0]                  r_ch;
    logic                            r_sym;
    logic [KW-1:0]                   r_k;
    logic [BW-1:0]                   r_b;
    logic                            r_out_valid, r_out_sat, r_ch_err;
    logic [ChW-1:0]                  r_out_ch;
    logic [DataWidth-1:0]            r_y;

    logic                   w_accept, w_ch_ok, w_shift, w_mac_last, w_center, w_msb;
    logic                   w_a, w_bb, w_sat;
    logic [LineW-1:0]       w_line;
    logic [DataWidth-1:0]   w_h, w_tap_a, w_tap_b, w_y;
    logic signed [AccW-1:0] w_hx, w_ta, w_tb, w_prod, w_term, w_step, w_shr;

    assign bus.in_ready = rstN && (r_state == IDLE) && !bus.coeff_load_in;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_ch_ok      = {1'b0, bus.in_ch} < ChLimit;
    assign w_shift      = bus.coeff_load_in && (r_state == IDLE || r_state == LOAD);
    assign w_msb        = (r_b == BW'(DataWidth - 1));
    assign w_center     = (r_k == KW'(NCoeffs - 1));
    assign w_mac_last   = w_center && w_msb;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (bus.coeff_load_in)        w_state_nxt = LOAD;
                  else if (w_accept && w_ch_ok) w_state_nxt = MAC;
            LOAD: if (!bus.coeff_load_in)       w_state_nxt = IDLE;
            MAC:  if (w_mac_last)               w_state_nxt = DONE;
            DONE:                               w_state_nxt = IDLE;
            default:                            w_state_nxt = IDLE;
        endcase
    end

    // Per cycle: one coefficient times one bit of its pre-added sample pair.
    always_comb begin
        w_line  = '0;
        w_h     = '0;
        w_tap_a = '0;
        w_tap_b = '0;
        for (int c = 0; c < NChannels; c++)
            if (r_ch == ChW'(c)) w_line = r_dl[c];
        for (int k = 0; k < NCoeffs; k++) begin
            if (r_k == KW'(k)) begin
                w_h     = r_coef[k*DataWidth +: DataWidth];
                w_tap_a = w_line[k*DataWidth +: DataWidth];
                w_tap_b = w_line[(NTaps-1-k)*DataWidth +: DataWidth];
            end
        end
    end

    assign w_a    = w_tap_a[r_b];
    assign w_bb   = w_tap_b[r_b] && !w_center;
    assign w_hx   = {{(AccW - DataWidth){w_h[DataWidth-1]}}, w_h};
    assign w_ta   = w_a  ? w_hx : '0;
    assign w_tb   = w_bb ? w_hx : '0;
    assign w_prod = r_sym ? (w_ta + w_tb) : (w_ta - w_tb);
    assign w_term = w_prod <<< r_b;
    assign w_step = w_msb ? -w_term : w_term;
    assign w_shr  = r_acc >>> (DataWidth - 1);

    always_comb begin
        w_sat = 1'b0;
        w_y   = w_shr[DataWidth-1:0];
        if (w_shr > YMax) begin
            w_sat = 1'b1;
            w_y   = YMax[DataWidth-1:0];
        end else if (w_shr < YMin) begin
            w_sat = 1'b1;
            w_y   = YMin[DataWidth-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_dl        <= '0;
            r_coef      <= '0;
            r_acc       <= '0;
            r_ch        <= '0;
            r_sym       <= 1'b0;
            r_k         <= '0;
            r_b         <= '0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
            r_out_ch    <= '0;
            r_y         <= '0;
            r_ch_err    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_ch_err    <= 1'b0;
            if (w_shift) r_coef <= {r_coef[CoefW-2:0], bus.coeff_in};
            if (w_accept) begin
                if (w_ch_ok) begin
                    for (int c = 0; c < NChannels; c++)
                        if (bus.in_ch == ChW'(c))
                            r_dl[c] <= {r_dl[c][LineW-DataWidth-1:0], bus.x};
                    r_ch  <= bus.in_ch;
                    r_sym <= bus.in_sym;
                    r_acc <= '0;
                    r_k   <= '0;
                    r_b   <= '0;
                end else begin
                    r_ch_err <= 1'b1;
                end
            end
            if (r_state == MAC) begin
                r_acc <= r_acc + w_step;
                if (w_msb) begin
                    r_b <= '0;
                    r_k <= r_k + KW'(1);
                end else begin
                    r_b <= r_b + BW'(1);
                end
            end
            if (r_state == DONE) begin
                r_out_valid <= 1'b1;
                r_y         <= w_y;
                r_out_ch    <= r_ch;
                r_out_sat   <= w_sat;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.y         = r_y;
    assign bus.out_sat   = r_out_sat;
    assign bus.ch_err    = r_ch_err;
endmodule

// File: tb/tb_fir_mc.sv
// Bench for fir_mc with three channels, so that an out-of-range channel index is reachable.
module tb_fir_mc;
    localparam int DW  = 12;
    localparam int NT  = 9;
    localparam int NCH = 3;
    localparam int NC  = (NT + 1) / 2;
    localparam int CHW = 2;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    fir_mc_if #(.DataWidth(DW), .ChW(CHW)) bus ();
    fir_mc #(.DataWidth(DW), .NTaps(NT), .NChannels(NCH)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int h[NC];
    int hist[NCH][NT];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < NT; i++) hist[c][i] = 0;
        for (int k = 0; k < NC; k++) h[k] = 0;
    endtask

    // Direct-form reference: expand h to all NTaps taps, then dot product with history.
    task automatic model_push(input int ch, input bit sym, input int xv,
                              output int ey, output bit esat);
        longint acc;
        int     c;
        for (int i = NT - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
        hist[ch][0] = xv;
        acc = 0;
        for (int i = 0; i < NT; i++) begin
            if (i < NC) c = h[i];
            else        c = sym ? h[NT-1-i] : -h[NT-1-i];
            acc += longint'(c) * longint'(hist[ch][i]);
        end
        acc  = acc >>> (DW - 1);
        esat = 1'b0;
        ey   = int'(acc);
        if (acc > 2047)       begin ey = 2047;  esat = 1'b1; end
        else if (acc < -2048) begin ey = -2048; esat = 1'b1; end
    endtask

    task automatic load_coeffs();
        logic [DW-1:0] hv;
        @(negedge clk);
        for (int k = NC - 1; k >= 0; k--) begin
            hv = DW'(h[k]);
            for (int b = DW - 1; b >= 0; b--) begin
                bus.coeff_load_in = 1'b1;
                bus.coeff_in      = hv[b];
                @(negedge clk);
            end
        end
        bus.coeff_load_in = 1'b0;
        bus.coeff_in      = 1'b0;
        @(negedge clk);
    endtask

    // Offer one sample, then wait (bounded) for its result; lat counts edges from accept.
    task automatic push(input int ch, input bit sym, input int xv,
                        output int oy, output int och, output bit osat, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_ch    = CHW'(ch);
        bus.in_sym   = sym;
        bus.x        = DW'(xv);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        oy   = int'($signed(bus.y));
        och  = int'(bus.out_ch);
        osat = bus.out_sat;
    endtask

    task automatic test_reset();
        rstN              = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_ch         = '0;
        bus.in_sym        = 1'b0;
        bus.x             = '0;
        bus.coeff_load_in = 1'b0;
        bus.coeff_in      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.ch_err !== 1'b0 ||
            bus.out_sat !== 1'b0 || bus.y !== '0 || bus.out_ch !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b sat=%b y=%0d ch=%0d expected all 0",
                     bus.in_ready, bus.out_valid, bus.ch_err, bus.out_sat, bus.y, bus.out_ch);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_impulse(input bit sym);
        int tbl_s[10] = '{500, 250, 0, 0, -250, 0, 0, 250, 500, 0};
        int tbl_a[10] = '{500, 250, 0, 0, -250, 0, 0, -250, -500, 0};
        int oy, och, lat, ey;
        bit osat, esat;
        h = '{1024, 512, 0, 0, -512};
        load_coeffs();
        for (int i = 0; i < 10; i++) begin
            push(0, sym, (i == 0) ? 1000 : 0, oy, och, osat, lat);
            model_push(0, sym, (i == 0) ? 1000 : 0, ey, esat);
            vectors++;
            if (oy !== (sym ? tbl_s[i] : tbl_a[i]) || och !== 0 || osat !== 1'b0 || lat !== 61) begin
                miscompares++;
                $display("FAIL impulse_sym%0d[%0d]: got y=%0d ch=%0d sat=%b lat=%0d expected y=%0d ch=0 sat=0 lat=61",
                         sym, i, oy, och, osat, lat, sym ? tbl_s[i] : tbl_a[i]);
            end
        end
    endtask

    task automatic test_isolation();
        int tbl[10] = '{500, 250, 0, 0, -250, 0, 0, 250, 500, 0};
        int oy, och, lat, ey;
        bit osat, esat;
        for (int i = 0; i < 10; i++) begin
            push(0, 1'b1, (i == 0) ? 1000 : 0, oy, och, osat, lat);
            model_push(0, 1'b1, (i == 0) ? 1000 : 0, ey, esat);
            vectors++;
            if (oy !== tbl[i] || och !== 0) begin
                miscompares++;
                $display("FAIL iso_ch0[%0d]: got y=%0d ch=%0d expected y=%0d ch=0", i, oy, och, tbl[i]);
            end
            push(1, 1'b1, 100, oy, och, osat, lat);
            model_push(1, 1'b1, 100, ey, esat);
            if (i >= 8) ey = 125;
            vectors++;
            if (oy !== ey || och !== 1) begin
                miscompares++;
                $display("FAIL iso_ch1[%0d]: got y=%0d ch=%0d expected y=%0d ch=1", i, oy, och, ey);
            end
        end
    endtask

    task automatic test_saturation();
        int oy, och, lat, ey;
        bit osat, esat;
        for (int k = 0; k < NC; k++) h[k] = 2047;
        load_coeffs();
        for (int i = 0; i < 18; i++) begin
            push(2, 1'b1, (i < 9) ? 2047 : -2048, oy, och, osat, lat);
            model_push(2, 1'b1, (i < 9) ? 2047 : -2048, ey, esat);
            if (i == 8)  begin ey = 2047;  esat = 1'b1; end
            if (i == 17) begin ey = -2048; esat = 1'b1; end
            vectors++;
            if (oy !== ey || osat !== esat || och !== 2) begin
                miscompares++;
                $display("FAIL sat[%0d]: got y=%0d sat=%b ch=%0d expected y=%0d sat=%b ch=2",
                         i, oy, osat, och, ey, esat);
            end
        end
    endtask

    task automatic test_handshake();
        int ey1, ey2, bad, lat, oy;
        bit es1, es2;
        h = '{1024, 512, 0, 0, -512};
        load_coeffs();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_ch    = 2'd0;
        bus.in_sym   = 1'b1;
        bus.x        = DW'(300);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        model_push(0, 1'b1, 300, ey1, es1);
        bad = 0;
        for (int e = 1; e <= 60; e++) begin
            bus.coeff_load_in = (e <= 50) ? 1'($urandom_range(1)) : 1'b0;
            bus.coeff_in      = 1'($urandom_range(1));
            @(posedge clk);
            #1;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
        end
        bus.coeff_load_in = 1'b0;
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL busy_window: got %0d cycles with ready/valid high expected 0", bad);
        end
        bus.in_valid = 1'b1;
        bus.in_ch    = 2'd1;
        bus.in_sym   = 1'b0;
        bus.x        = DW'(-77);
        @(posedge clk);
        #1;
        oy = int'($signed(bus.y));
        vectors++;
        if (bus.out_valid !== 1'b1 || oy !== ey1 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL strobe_e61: got vld=%b y=%0d rdy=%b expected vld=1 y=%0d rdy=1",
                     bus.out_valid, oy, bus.in_ready, ey1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        model_push(1, 1'b0, -77, ey2, es2);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL accept_e62: got vld=%b rdy=%b expected vld=0 rdy=0", bus.out_valid, bus.in_ready);
        end
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        oy = int'($signed(bus.y));
        vectors++;
        if (lat !== 61 || oy !== ey2 || bus.out_ch !== 2'd1) begin
            miscompares++;
            $display("FAIL retry_result: got lat=%0d y=%0d ch=%0d expected lat=61 y=%0d ch=1",
                     lat, oy, bus.out_ch, ey2);
        end
        // Load wins over a simultaneous sample offer.
        @(negedge clk);
        bus.coeff_load_in = 1'b1;
        bus.in_valid      = 1'b1;
        bus.in_ch         = 2'd0;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL load_priority_ready: got %b expected 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.coeff_load_in = 1'b0;
        bus.in_valid      = 1'b0;
        bad = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL load_priority_strobe: got %0d strobes expected 0", bad);
        end
        load_coeffs();
    endtask

    task automatic test_faults();
        int oy, och, lat, ey, bad, y_before;
        bit osat, esat;
        @(negedge clk);
        y_before     = int'($signed(bus.y));
        bus.in_valid = 1'b1;
        bus.in_ch    = 2'd3;
        bus.x        = DW'(555);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.ch_err !== 1'b1 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ch_err_pulse: got err=%b rdy=%b expected err=1 rdy=1", bus.ch_err, bus.in_ready);
        end
        bad = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0 || bus.ch_err !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0 || int'($signed(bus.y)) !== y_before) begin
            miscompares++;
            $display("FAIL ch_err_quiet: got %0d bad cycles y=%0d expected 0 bad y=%0d",
                     bad, $signed(bus.y), y_before);
        end
        // Prime history, then abort a computation with reset.
        push(0, 1'b1, 700, oy, och, osat, lat);
        model_push(0, 1'b1, 700, ey, esat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_ch    = 2'd0;
        bus.x        = DW'(900);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.y !== '0 || bus.out_sat !== 1'b0 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_mac_reset: got vld=%b y=%0d sat=%b rdy=%b expected all 0",
                     bus.out_valid, $signed(bus.y), bus.out_sat, bus.in_ready);
        end
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) bad++;
        end
        @(negedge clk);
        rstN = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL mid_mac_no_strobe: got %0d strobes expected 0", bad);
        end
        model_reset();
        push(2, 1'b1, 1234, oy, och, osat, lat);
        model_push(2, 1'b1, 1234, ey, esat);
        vectors++;
        if (oy !== ey || osat !== esat) begin
            miscompares++;
            $display("FAIL coef_cleared: got y=%0d sat=%b expected y=%0d sat=%b", oy, osat, ey, esat);
        end
        h = '{1024, 512, 0, 0, -512};
        load_coeffs();
        for (int i = 0; i < 2; i++) begin
            push(0, 1'b1, (i == 0) ? 1000 : 0, oy, och, osat, lat);
            model_push(0, 1'b1, (i == 0) ? 1000 : 0, ey, esat);
            vectors++;
            if (oy !== ey || oy !== ((i == 0) ? 500 : 250)) begin
                miscompares++;
                $display("FAIL post_reset_impulse[%0d]: got y=%0d expected y=%0d", i, oy, ey);
            end
        end
    endtask

    task automatic test_random();
        int oy, och, lat, ey, ch, xv;
        bit osat, esat, sym;
        for (int k = 0; k < NC; k++) h[k] = int'($urandom_range(4095)) - 2048;
        load_coeffs();
        for (int i = 0; i < 24; i++) begin
            ch  = int'($urandom_range(NCH - 1));
            sym = 1'($urandom_range(1));
            xv  = int'($urandom_range(4095)) - 2048;
            push(ch, sym, xv, oy, och, osat, lat);
            model_push(ch, sym, xv, ey, esat);
            vectors++;
            if (oy !== ey || osat !== esat || och !== ch || lat !== 61) begin
                miscompares++;
                $display("FAIL random[%0d]: got y=%0d sat=%b ch=%0d lat=%0d expected y=%0d sat=%b ch=%0d lat=61",
                         i, oy, osat, och, lat, ey, esat, ch);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse(1'b1);
        test_impulse(1'b0);
        test_isolation();
        test_saturation();
        test_handshake();
        test_faults();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
